// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus.
// Groups the producer handshakes (ALU writeback, memory-load return), the
// issue-side scoreboard query and the register-file write outputs.
//   master : producers / issue logic / register file side
//   slave  : the arbiter itself
interface regfile_write_arbiter_if #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8
);
    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_ready;
    logic [ADDR_W-1:0]   rs1;
    logic [ADDR_W-1:0]   rs2;
    logic                raw_hazard;
    logic                flush;
    logic                reg_write;
    logic [ADDR_W-1:0]   Register_Destination;
    logic [DATA_W-1:0]   data_in;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, rs1, rs2, flush,
        input  alu_ready, mem_ready, issue_ready, raw_hazard,
        input  reg_write, Register_Destination, data_in, busy_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, rs1, rs2, flush,
        output alu_ready, mem_ready, issue_ready, raw_hazard,
        output reg_write, Register_Destination, data_in, busy_mask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Round-robin arbitration between ALU writeback and load return, registered
// write path (latency 1), and a per-register busy bit set on issue and
// cleared when the write lands.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_write_arbiter_if.slave (handshakes, scoreboard, write port)
module regfile_write_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {LAST_ALU = 1'b0, LAST_MEM = 1'b1} last_e;

    last_e               last_q;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                reg_write_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   data_q;
    logic                alu_gnt;
    logic                mem_gnt;
    logic                issue_acc;

    // Grants are suppressed during reset so no transfer can be accepted.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (last_q == LAST_MEM) alu_gnt = 1'b1;
                else                    mem_gnt = 1'b1;
            end else begin
                alu_gnt = bus.alu_valid;
                mem_gnt = bus.mem_valid;
            end
        end
    end

    assign issue_acc = bus.issue_valid & ~busy_q[bus.issue_rd] & ~rst & ~bus.flush;

    // Clear for the landing write is applied before the issue set, so a
    // same-index set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) busy_d[rd_q] = 1'b0;
        if (issue_acc)   busy_d[bus.issue_rd] = 1'b1;
        if (bus.flush)   busy_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= LAST_MEM;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= alu_gnt | mem_gnt;
            if (alu_gnt) begin
                last_q <= LAST_ALU;
                rd_q   <= bus.alu_rd;
                data_q <= bus.alu_data;
            end else if (mem_gnt) begin
                last_q <= LAST_MEM;
                rd_q   <= bus.mem_rd;
                data_q <= bus.mem_data;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.alu_ready            = alu_gnt;
    assign bus.mem_ready            = mem_gnt;
    assign bus.issue_ready          = ~busy_q[bus.issue_rd] & ~rst;
    assign bus.raw_hazard           = busy_q[bus.rs1] | busy_q[bus.rs2];
    assign bus.reg_write            = reg_write_q;
    assign bus.Register_Destination = rd_q;
    assign bus.data_in              = data_q;
    assign bus.busy_mask            = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed test-plan steps
// followed by randomized traffic, all compared against a behavioural model.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) bus ();

    regfile_write_arbiter #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state
    bit m_busy[8];
    bit m_last_mem;
    bit m_we;
    int m_rd;
    int m_data;
    bit m_ga;
    bit m_gm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        m_last_mem = 1'b1;
        m_we = 1'b0;
        m_rd = 0;
        m_data = 0;
    endtask

    function automatic logic [7:0] pack_busy();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) if (m_busy[i]) v = v | 8'(1 << i);
        return v;
    endfunction

    // One clock cycle: inputs are already set; check, then advance the model.
    task automatic cyc();
        bit accept;
        int ir;
        if (rst) model_reset();
        #1;
        m_ga = 0;
        m_gm = 0;
        if (!rst) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (m_last_mem) m_ga = 1; else m_gm = 1;
            end else begin
                m_ga = bus.alu_valid;
                m_gm = bus.mem_valid;
            end
        end
        ir = int'(bus.issue_rd);
        chk("alu_ready",   32'(bus.alu_ready), 32'(m_ga));
        chk("mem_ready",   32'(bus.mem_ready), 32'(m_gm));
        chk("issue_ready", 32'(bus.issue_ready), 32'(!rst && !m_busy[ir]));
        chk("raw_hazard",  32'(bus.raw_hazard),
            32'(m_busy[int'(bus.rs1)] || m_busy[int'(bus.rs2)]));
        chk("reg_write",   32'(bus.reg_write), 32'(m_we));
        chk("reg_dest",    32'(bus.Register_Destination), 32'(m_rd));
        chk("data_in",     32'(bus.data_in), 32'(m_data));
        chk("busy_mask",   32'(bus.busy_mask), 32'(pack_busy()));
        @(posedge clk);
        if (!rst) begin
            accept = bus.issue_valid && !m_busy[ir];
            if (bus.flush) begin
                for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            end else begin
                if (m_we) m_busy[m_rd] = 1'b0;
                if (accept) m_busy[ir] = 1'b1;
            end
            m_we = m_ga || m_gm;
            if (m_ga) begin
                m_rd = int'(bus.alu_rd);
                m_data = int'(bus.alu_data);
                m_last_mem = 1'b0;
            end else if (m_gm) begin
                m_rd = int'(bus.mem_rd);
                m_data = int'(bus.mem_data);
                m_last_mem = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset holds ready low even with a valid request
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 8'hA5;
        #1;
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_busy", 32'(bus.busy_mask), 32'h00);
        cyc();

        // Release: ALU accepted in the same cycle, write lands next cycle
        rst = 1'b0;
        #1;
        chk("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc();
        chk("single_we", 32'(bus.reg_write), 32'd1);
        chk("single_rd", 32'(bus.Register_Destination), 32'd3);
        chk("single_data", 32'(bus.data_in), 32'hA5);
        bus.alu_valid = 1'b0;
        cyc();
        chk("single_we_off", 32'(bus.reg_write), 32'd0);

        // Contention after reset: ALU, MEM, ALU, MEM
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 8'd11;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 8'd22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_grant_alu", 32'(bus.alu_ready), 32'((i % 2) == 0));
            cyc();
            chk("cont_we", 32'(bus.reg_write), 32'd1);
            chk("cont_rd", 32'(bus.Register_Destination), ((i % 2) == 0) ? 32'd1 : 32'd2);
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        cyc();

        // Scoreboard: issue R5, hazards, load to R5 clears it
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd5;
        cyc();
        bus.issue_valid = 1'b0;
        chk("sb_busy20", 32'(bus.busy_mask), 32'h20);
        bus.rs1 = 3'd5; bus.issue_valid = 1'b1;
        #1;
        chk("sb_raw", 32'(bus.raw_hazard), 32'd1);
        chk("sb_waw", 32'(bus.issue_ready), 32'd0);
        cyc();
        bus.issue_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd5; bus.mem_data = 8'h77;
        cyc();
        bus.mem_valid = 1'b0;
        chk("sb_land_we", 32'(bus.reg_write), 32'd1);
        cyc();
        chk("sb_clear", 32'(bus.busy_mask), 32'h00);
        chk("sb_raw_clear", 32'(bus.raw_hazard), 32'd0);
        bus.rs1 = 3'd0;

        // Same-index set and clear: set wins
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd4; bus.alu_data = 8'h44;
        cyc();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd4;
        cyc();
        bus.issue_valid = 1'b0;
        chk("setclr_same", 32'(bus.busy_mask), 32'h10);

        // Different indices: clear R4, set R6
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd4; bus.alu_data = 8'h45;
        cyc();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 3'd6;
        cyc();
        bus.issue_valid = 1'b0;
        chk("setclr_diff", 32'(bus.busy_mask), 32'h40);

        // Clear R6 then build 0F and flush it (with an ignored issue)
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd6;
        cyc();
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.issue_valid = 1'b1; bus.issue_rd = 3'(i);
            cyc();
        end
        chk("pre_flush", 32'(bus.busy_mask), 32'h0F);
        bus.issue_rd = 3'd7; bus.flush = 1'b1;
        cyc();
        bus.issue_valid = 1'b0; bus.flush = 1'b0;
        chk("flush", 32'(bus.busy_mask), 32'h00);

        // Reset right after an accepted transfer discards the write
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 8'h33;
        cyc();
        bus.alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.reg_write), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_we_after", 32'(bus.reg_write), 32'd0);

        // Randomized traffic; producers hold requests until accepted
        for (int n = 0; n < 400; n++) begin
            if (!bus.alu_valid || m_ga) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_rd = 3'($urandom_range(0, 7));
                bus.alu_data = 8'($urandom_range(0, 255));
            end
            if (!bus.mem_valid || m_gm) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_rd = 3'($urandom_range(0, 7));
                bus.mem_data = 8'($urandom_range(0, 255));
            end
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd = 3'($urandom_range(0, 7));
            bus.rs1 = 3'($urandom_range(0, 7));
            bus.rs2 = 3'($urandom_range(0, 7));
            bus.flush = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 40) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two producers: ALU writeback and memory-load return. Arbitration is round-robin, with a valid/ready handshake on each side. A per-register pending-write scoreboard lets the FSM stall issue on RAW and WAW hazards. It sits between the ALU/load unit and the register file write inputs (reg_write, destination, data).

Parameters:
NUM_REGS, 8, number of architectural registers (scoreboard width)
ADDR_W, 3, register index width (log2 NUM_REGS)
DATA_W, 8, register data width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU has a result to write
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU write accepted this cycle
mem_valid  in  1  load unit has data to write
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load write accepted this cycle
issue_valid  in  1  FSM issuing an instruction that will write issue_rd
issue_rd  in  ADDR_W  destination of issuing instruction
issue_ready  out  1  issue allowed (no WAW on issue_rd)
rs1  in  ADDR_W  source operand 1 of issuing instruction
rs2  in  ADDR_W  source operand 2 of issuing instruction
raw_hazard  out  1  rs1 or rs2 has a pending write
flush  in  1  synchronous clear of scoreboard
reg_write  out  1  register file write enable
Register_Destination  out  ADDR_W  register file write address
data_in  out  DATA_W  register file write data
busy_mask  out  NUM_REGS  pending-write bit per register

Behaviour:
- Reset (async, rst=1): reg_write=0, Register_Destination=0, data_in=0, busy_mask=0, last-grant pointer=MEM (so ALU wins the first tie). alu_ready, mem_ready and issue_ready are forced to 0 while rst=1.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Neither valid: no grant; pointer unchanged.
- alu_ready/mem_ready = grant to that side. A transfer occurs when valid & ready. The pointer updates only on a transfer.
- Requesters hold valid/rd/data stable until ready. The arbiter never drops an accepted transfer.
- Write path is registered, latency 1:
  - Transfer in cycle N drives reg_write=1 with the granted rd and data during cycle N+1. The register file captures it at the end of N+1.
  - No transfer in cycle N drives reg_write=0 in N+1. Register_Destination and data_in hold their previous values.
- Back-to-back transfers are allowed every cycle (full throughput).
- Scoreboard:
  - Issue accepted (issue_valid & issue_ready): sets busy[issue_rd] at the clock edge.
  - Clear: busy[Register_Destination] clears on the edge ending a cycle with reg_write=1, i.e. when data lands.
  - Same index set and cleared in one cycle: set wins, bit stays 1.
  - Different indices set and cleared in one cycle: both take effect.
- issue_ready = ~busy[issue_rd] & ~rst (combinational). A second writer to an in-flight register is stalled.
- raw_hazard = busy[rs1] | busy[rs2] (combinational). No forwarding: the FSM waits until the write has landed.
- Writes that arrive without a prior issue are legal. They clear an already-0 bit with no effect.
- flush=1: busy_mask cleared next edge, and issues in the same cycle are ignored. The write path is unaffected: an in-flight reg_write still completes.
- rst asserted mid-transfer: the pending registered write is discarded (reg_write=0 immediately). No partial write reaches the register file.

Test Plan:
- Reset: rst=1 with alu_valid=1 -> alu_ready=0, reg_write=0, busy_mask=8'h00. Release rst -> alu_ready=1 the same cycle.
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=8'hA5 at cycle N -> cycle N+1 has reg_write=1, Register_Destination=3, data_in=8'hA5. Cycle N+2 has reg_write=0.
- Contention: alu_valid and mem_valid held high for 4 cycles (ALU rd=1/data=11, MEM rd=2/data=22) -> grants ALU, MEM, ALU, MEM, and reg_write stays high for 4 consecutive cycles.
- Scoreboard:
  - Issue issue_rd=5 -> busy_mask=8'h20 next cycle.
  - Then rs1=5 -> raw_hazard=1, and issue_rd=5 -> issue_ready=0.
  - mem write to rd 5 -> reg_write cycle, then busy_mask=8'h00 and raw_hazard=0.
- Simultaneous set/clear: reg_write active to R4 while a new issue to R4 is accepted -> busy_mask[4]=1 afterwards. Same scenario with issue to R6 instead -> busy_mask=8'h40.
- Flush and mid-reset:
  - busy_mask=8'h0F, flush=1 -> 8'h00 next cycle.
  - rst pulsed in the cycle after an accepted transfer -> reg_write never observed high.
